// File: rtl/snd_pkg.sv
// snd_pkg: shared definitions for the sound channel sequencers.
//   - NR30/NR34 bit positions used by the wave channel decode
//   - wave channel state encoding
//   - wave RAM geometry and the nibble-index advance helper
package snd_pkg;

    // NR30 fields
    localparam int DAC_EN_BIT = 7;
    localparam int BANK_BIT   = 6;
    localparam int DIM_BIT    = 5;

    // NR34 fields
    localparam int TRIG_BIT   = 7;
    localparam int LEN_EN_BIT = 6;

    localparam int WAVE_NIBBLES = 64;
    localparam int WAVE_IDX_W   = $clog2(WAVE_NIBBLES);
    localparam int TIMER_W      = 13;

    typedef enum logic {WC_OFF, WC_PLAY} wave_state_t;

    // 32-nibble mode wraps inside the selected bank; 64-nibble mode walks
    // both banks, so bit 5 becomes part of the counter.
    function automatic logic [WAVE_IDX_W-1:0] next_index(
        input logic [WAVE_IDX_W-1:0] idx,
        input logic                  dim,
        input logic                  bank
    );
        if (dim) begin
            return idx + 6'd1;
        end
        return {bank, idx[4:0] + 5'd1};
    endfunction

endpackage

// File: rtl/sound_length_counter.sv
// sound_length_counter: free-running length-tick prescaler plus a down-counting
// length counter with expiry detect. Shared by the square, wave and noise
// channels; MAX_LEN selects the channel's full-scale length (64 or 256).
//
// Ports:
//   clk_i       system clock
//   reset_i     synchronous, active-high
//   load_i      length register write strobe (highest priority)
//   load_val_i  value loaded on load_i (MAX_LEN - register value)
//   trigger_i   accepted channel trigger: reloads MAX_LEN when the counter is 0
//   len_en_i    length enable currently in effect
//   count_o     live counter value
//   expire_o    combinational: this cycle's tick takes the counter from 1 to 0
module sound_length_counter #(
    parameter int LEN_TICK_DIV = 65536,
    parameter int MAX_LEN      = 256,
    parameter int CNT_W        = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             trigger_i,
    input  logic             len_en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_o
);

    localparam int PRE_W = $clog2(LEN_TICK_DIV);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             len_tick;
    logic             dec_ok;

    assign len_tick = (presc_q == PRE_W'(LEN_TICK_DIV - 1));
    assign dec_ok   = len_tick && len_en_i && (count_q != '0);

    always_comb begin
        presc_d  = len_tick ? '0 : presc_q + PRE_W'(1);
        count_d  = count_q;
        expire_o = 1'b0;
        // A register write beats a trigger, and either one swallows a
        // coincident tick.
        if (load_i) begin
            count_d = load_val_i;
        end else if (trigger_i) begin
            if (count_q == '0) begin
                count_d = CNT_W'(MAX_LEN);
            end
        end else if (dec_ok) begin
            count_d  = count_q - CNT_W'(1);
            expire_o = (count_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/wave_channel_ctrl.sv
// wave_channel_ctrl: sequencer for sound channel 3 (wave channel).
// Decodes NR30/NR31/NR33/NR34, runs the frequency timer as a clock enable,
// handles trigger / length expiry / DAC-off, and produces the wave-RAM nibble
// index and bank select for the sample datapath.
//
// Ports:
//   system_clock   system clock
//   reset          synchronous, active-high
//   nr30           [7] DAC enable, [6] bank, [5] dimension (1 = 64 nibbles)
//   nr31, nr31_wr  length load value and its write strobe
//   nr33           frequency low byte
//   nr34, nr34_wr  [7] trigger, [6] length enable, [2:0] frequency high
//   channel_on     channel playing (NR52 bit 2)
//   sample_index   nibble index into 64-nibble wave RAM, bit 5 = bank
//   sample_tick    one-cycle pulse when sample_index advances
//   cpu_bank       bank open to CPU access (inverse of the playing bank)
//
// Build option WAVE_CTRL_LEN_READBACK_EN adds:
//   len_remaining  live 9-bit length counter
//   len_expired    one-cycle pulse when length expiry forces the channel off
//
// state   | meaning
// WC_OFF  | silent; index and timer frozen, cpu_bank follows NR30 bank
// WC_PLAY | timer running, index advancing on each timer expiry
module wave_channel_ctrl
    import snd_pkg::*;
#(
    parameter int LEN_TICK_DIV = 65536,
    parameter int TIMER_MULT   = 4
) (
    input  logic       system_clock,
    input  logic       reset,
    input  logic [7:0] nr30,
    input  logic [7:0] nr31,
    input  logic       nr31_wr,
    input  logic [7:0] nr33,
    input  logic [7:0] nr34,
    input  logic       nr34_wr,
    output logic       channel_on,
    output logic [5:0] sample_index,
    output logic       sample_tick,
    output logic       cpu_bank
`ifdef WAVE_CTRL_LEN_READBACK_EN
    ,
    output logic [8:0] len_remaining,
    output logic       len_expired
`endif
);

    wave_state_t             state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [WAVE_IDX_W-1:0]   index_q, index_d;
    logic                    tick_q, tick_d;
    logic                    cpu_bank_q, cpu_bank_d;
    logic                    len_en_q;

    logic                    dac_on;
    logic                    trig_ok;
    logic                    play_active;
    logic                    len_en_eff;
    logic                    len_expire;
    logic [8:0]              len_count;
    logic [8:0]              len_load_val;
    logic [10:0]             freq;
    logic [31:0]             reload_full;
    logic [TIMER_W-1:0]      reload;

    assign dac_on      = nr30[DAC_EN_BIT];
    assign trig_ok     = nr34_wr && nr34[TRIG_BIT] && dac_on;
    // DAC-off silences the channel in the same cycle, ahead of the state update.
    assign play_active = (state_q == WC_PLAY) && dac_on;
    assign len_en_eff  = nr34_wr ? nr34[LEN_EN_BIT] : len_en_q;

    assign freq         = {nr34[2:0], nr33};
    // (2048 - f) * mult spans 4..8192; 8192 truncates to 0, and a timer
    // started at 0 wraps to 8191 first, so it still counts 8192 cycles.
    assign reload_full  = (32'd2048 - {21'd0, freq}) * TIMER_MULT;
    assign reload       = reload_full[TIMER_W-1:0];
    assign len_load_val = 9'd256 - {1'b0, nr31};

    sound_length_counter #(
        .LEN_TICK_DIV (LEN_TICK_DIV),
        .MAX_LEN      (256)
    ) u_len (
        .clk_i      (system_clock),
        .reset_i    (reset),
        .load_i     (nr31_wr),
        .load_val_i (len_load_val),
        .trigger_i  (trig_ok),
        .len_en_i   (len_en_eff),
        .count_o    (len_count),
        .expire_o   (len_expire)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        index_d = index_q;
        tick_d  = 1'b0;
        if (trig_ok) begin
            state_d = WC_PLAY;
            timer_d = reload;
            index_d = {nr30[BANK_BIT], 5'd0};
        end else if (!dac_on || len_expire) begin
            state_d = WC_OFF;
        end else if (play_active) begin
            if (timer_q == TIMER_W'(1)) begin
                timer_d = reload;
                tick_d  = 1'b1;
                index_d = next_index(index_q, nr30[DIM_BIT], nr30[BANK_BIT]);
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end
        cpu_bank_d = (state_d == WC_PLAY) ? ~index_d[5] : ~nr30[BANK_BIT];
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q    <= WC_OFF;
            timer_q    <= '0;
            index_q    <= '0;
            tick_q     <= 1'b0;
            cpu_bank_q <= 1'b1;
            len_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            index_q    <= index_d;
            tick_q     <= tick_d;
            cpu_bank_q <= cpu_bank_d;
            len_en_q   <= len_en_eff;
        end
    end

    assign channel_on   = play_active;
    assign sample_index = index_q;
    assign sample_tick  = tick_q;
    assign cpu_bank     = cpu_bank_q;

`ifdef WAVE_CTRL_LEN_READBACK_EN
    logic len_exp_q;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            len_exp_q <= 1'b0;
        end else begin
            len_exp_q <= len_expire && (state_q == WC_PLAY);
        end
    end

    assign len_remaining = len_count;
    assign len_expired   = len_exp_q;
`else
    logic unused_len_count;
    assign unused_len_count = ^len_count;
`endif

    logic unused_bits;
    assign unused_bits = ^{nr30[4:0], nr34[5:3], reload_full[31:TIMER_W]};

endmodule

// File: tb/tb_wave_channel_ctrl.sv
module tb_wave_channel_ctrl;

    localparam int DIV = 16;

    logic       system_clock;
    logic       reset;
    logic [7:0] nr30, nr31, nr33, nr34;
    logic       nr31_wr, nr34_wr;
    logic       channel_on;
    logic [5:0] sample_index;
    logic       sample_tick;
    logic       cpu_bank;
`ifdef WAVE_CTRL_LEN_READBACK_EN
    logic [8:0] len_remaining;
    logic       len_expired;
`endif

    int checks = 0;
    int errors = 0;
    int pm;
    logic [5:0] exp_q[$];

    wave_channel_ctrl #(.LEN_TICK_DIV(DIV), .TIMER_MULT(4)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .nr30         (nr30),
        .nr31         (nr31),
        .nr31_wr      (nr31_wr),
        .nr33         (nr33),
        .nr34         (nr34),
        .nr34_wr      (nr34_wr),
        .channel_on   (channel_on),
        .sample_index (sample_index),
        .sample_tick  (sample_tick),
        .cpu_bank     (cpu_bank)
`ifdef WAVE_CTRL_LEN_READBACK_EN
        ,
        .len_remaining (len_remaining),
        .len_expired   (len_expired)
`endif
    );

    initial begin
        system_clock = 1'b0;
        forever #5 system_clock = ~system_clock;
    end

    // Reference 256 Hz phase: a length tick lands on the edge that ends a
    // cycle in which pm == DIV-1, counting from reset release.
    always @(posedge system_clock) begin
        if (reset) pm <= 0;
        else       pm <= (pm == DIV - 1) ? 0 : pm + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic write_nr34(input logic [7:0] v);
        nr34 = v; nr34_wr = 1'b1;
        @(negedge system_clock);
        nr34_wr = 1'b0;
    endtask

    task automatic write_nr31(input logic [7:0] v);
        nr31 = v; nr31_wr = 1'b1;
        @(negedge system_clock);
        nr31_wr = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int gap, output bit ok);
        gap = 0; ok = 1'b0;
        while (gap < budget) begin
            @(negedge system_clock);
            gap++;
            if (sample_tick) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        nr30 = 8'h00; nr31 = 8'h00; nr33 = 8'h00; nr34 = 8'h00;
        nr31_wr = 1'b0; nr34_wr = 1'b0;
        repeat (3) @(negedge system_clock);
        checks++; if (channel_on !== 1'b0) begin errors++; $display("FAIL reset_channel_on: got %b want 0", channel_on); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", sample_tick); end
        checks++; if (sample_index !== 6'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", sample_index); end
        checks++; if (cpu_bank !== 1'b1) begin errors++; $display("FAIL reset_cpu_bank: got %b want 1", cpu_bank); end
        reset = 1'b0;
        repeat (2) @(negedge system_clock);
        checks++; if (channel_on !== 1'b0) begin errors++; $display("FAIL post_reset_channel_on: got %b want 0", channel_on); end
    endtask

    task automatic test_basic;
        int gap; bit ok; logic [5:0] e;
        nr30 = 8'h80; nr33 = 8'hFF;
        write_nr34(8'h87);
        checks++; if (channel_on !== 1'b1) begin errors++; $display("FAIL basic_on: got %b want 1", channel_on); end
        checks++; if (sample_index !== 6'd0) begin errors++; $display("FAIL basic_start: got %0d want 0", sample_index); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL basic_trig_tick: got %b want 0", sample_tick); end
        for (int i = 1; i <= 33; i++) exp_q.push_back(6'(i % 32));
        while (exp_q.size() > 0) begin
            wait_tick(20, gap, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_timeout: no sample_tick in 20 cycles"); exp_q.delete(); break; end
            e = exp_q.pop_front();
            checks++; if (gap !== 4) begin errors++; $display("FAIL basic_gap: got %0d want 4", gap); end
            checks++; if (sample_index !== e) begin errors++; $display("FAIL basic_index: got %0d want %0d", sample_index, e); end
        end
    endtask

    task automatic test_freq;
        int gap; bit ok; logic [5:0] e;
        nr33 = 8'hFE;
        write_nr34(8'h87);
        checks++; if (sample_index !== 6'd0) begin errors++; $display("FAIL freq_restart: got %0d want 0", sample_index); end
        for (int i = 1; i <= 3; i++) exp_q.push_back(6'(i));
        while (exp_q.size() > 0) begin
            wait_tick(30, gap, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL freq_timeout: no sample_tick in 30 cycles"); exp_q.delete(); break; end
            e = exp_q.pop_front();
            checks++; if (gap !== 8) begin errors++; $display("FAIL freq_gap_2046: got %0d want 8", gap); end
            checks++; if (sample_index !== e) begin errors++; $display("FAIL freq_index: got %0d want %0d", sample_index, e); end
        end
        nr33 = 8'h00;
        write_nr34(8'h80);
        exp_q.push_back(6'd1);
        wait_tick(9000, gap, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL freq0_timeout: no sample_tick in 9000 cycles"); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            checks++; if (gap !== 8192) begin errors++; $display("FAIL freq0_gap: got %0d want 8192", gap); end
            checks++; if (sample_index !== e) begin errors++; $display("FAIL freq0_index: got %0d want %0d", sample_index, e); end
        end
    endtask

    task automatic test_dimension;
        int gap; bit ok; logic [5:0] e;
        nr30 = 8'hE0; nr33 = 8'hFF;
        write_nr34(8'h87);
        checks++; if (sample_index !== 6'd32) begin errors++; $display("FAIL dim_start: got %0d want 32", sample_index); end
        checks++; if (cpu_bank !== 1'b0) begin errors++; $display("FAIL dim_cpu_bank_start: got %b want 0", cpu_bank); end
        for (int i = 33; i <= 96; i++) exp_q.push_back(6'(i % 64));
        while (exp_q.size() > 0) begin
            wait_tick(20, gap, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL dim_timeout: no sample_tick in 20 cycles"); exp_q.delete(); break; end
            e = exp_q.pop_front();
            checks++; if (sample_index !== e) begin errors++; $display("FAIL dim_index: got %0d want %0d", sample_index, e); end
            checks++; if (cpu_bank !== !e[5]) begin errors++; $display("FAIL dim_cpu_bank: got %b want %b", cpu_bank, !e[5]); end
        end
    endtask

    task automatic test_back_to_back;
        int gap; bit ok; logic [5:0] e;
        nr30 = 8'hC0;
        write_nr34(8'h87);
        checks++; if (sample_index !== 6'd32) begin errors++; $display("FAIL b2b_start: got %0d want 32", sample_index); end
        wait_tick(20, gap, ok);
        checks++; if (!(ok && sample_index === 6'd33)) begin errors++; $display("FAIL b2b_first: got %0d want 33", sample_index); end
        // Timer now at full reload; its expiry cycle is three cycles on.
        repeat (3) @(negedge system_clock);
        write_nr34(8'h87);
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL collide_tick: got %b want 0", sample_tick); end
        checks++; if (sample_index !== 6'd32) begin errors++; $display("FAIL collide_index: got %0d want 32", sample_index); end
        for (int i = 1; i <= 32; i++) exp_q.push_back({1'b1, 5'(i % 32)});
        while (exp_q.size() > 0) begin
            wait_tick(20, gap, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_timeout: no sample_tick in 20 cycles"); exp_q.delete(); break; end
            e = exp_q.pop_front();
            checks++; if (gap !== 4) begin errors++; $display("FAIL b2b_gap: got %0d want 4", gap); end
            checks++; if (sample_index !== e) begin errors++; $display("FAIL b2b_index: got %0d want %0d", sample_index, e); end
        end
    endtask

    task automatic test_dac_off;
        int nt; logic [5:0] held;
        repeat (2) @(negedge system_clock);
        nr30 = 8'h00;
        #1;
        checks++; if (channel_on !== 1'b0) begin errors++; $display("FAIL dac_off_same_cycle: got %b want 0", channel_on); end
        held = sample_index;
        nt = 0;
        repeat (20) begin @(negedge system_clock); if (sample_tick) nt++; end
        checks++; if (nt !== 0) begin errors++; $display("FAIL dac_off_ticks: got %0d want 0", nt); end
        checks++; if (sample_index !== held) begin errors++; $display("FAIL dac_off_frozen: got %0d want %0d", sample_index, held); end
        checks++; if (cpu_bank !== 1'b1) begin errors++; $display("FAIL dac_off_cpu_bank: got %b want 1", cpu_bank); end
        write_nr34(8'h87);
        nt = 0;
        repeat (20) begin @(negedge system_clock); if (sample_tick || channel_on) nt++; end
        checks++; if (nt !== 0) begin errors++; $display("FAIL dac_off_retrigger: active cycles got %0d want 0", nt); end
    endtask

    task automatic test_length;
        int ticks; int pulses;
        nr30 = 8'h80; nr33 = 8'hFF;
        write_nr31(8'hFE);
        write_nr34(8'hC7);
        ticks = 0; pulses = 0;
        for (int i = 0; i < 200; i++) begin
`ifdef WAVE_CTRL_LEN_READBACK_EN
            if (len_expired) pulses++;
`endif
            if (!channel_on) break;
            if (pm == DIV - 1) ticks++;
            @(negedge system_clock);
        end
        checks++; if (channel_on !== 1'b0) begin errors++; $display("FAIL len_expire_off: channel_on got %b want 0", channel_on); end
        checks++; if (ticks !== 2) begin errors++; $display("FAIL len_expire_ticks: got %0d want 2", ticks); end
`ifdef WAVE_CTRL_LEN_READBACK_EN
        repeat (5) begin @(negedge system_clock); if (len_expired) pulses++; end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL len_expired_pulse: got %0d want 1", pulses); end
        checks++; if (len_remaining !== 9'd0) begin errors++; $display("FAIL len_remaining_zero: got %0d want 0", len_remaining); end
`endif
        // Counter is 0 here: the trigger must reload the full 256.
        write_nr34(8'hC7);
        ticks = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!channel_on) break;
            if (pm == DIV - 1) ticks++;
            @(negedge system_clock);
        end
        checks++; if (channel_on !== 1'b0) begin errors++; $display("FAIL len256_off: channel_on got %b want 0", channel_on); end
        checks++; if (ticks !== 256) begin errors++; $display("FAIL len256_ticks: got %0d want 256", ticks); end
    endtask

    task automatic test_length_collision;
        int ticks;
        nr30 = 8'h80;
        write_nr31(8'h00);
        write_nr34(8'hC7);
        for (int i = 0; i < 2 * DIV; i++) begin
            if (pm == DIV - 1) break;
            @(negedge system_clock);
        end
        checks++; if (pm !== DIV - 1) begin errors++; $display("FAIL lencol_align: pm got %0d want %0d", pm, DIV - 1); end
        write_nr31(8'hFE);
`ifdef WAVE_CTRL_LEN_READBACK_EN
        checks++; if (len_remaining !== 9'd2) begin errors++; $display("FAIL lencol_count: got %0d want 2", len_remaining); end
`endif
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            if (!channel_on) break;
            if (pm == DIV - 1) ticks++;
            @(negedge system_clock);
        end
        checks++; if (ticks !== 2 || channel_on !== 1'b0) begin errors++; $display("FAIL lencol_ticks: got %0d on=%b want 2 on=0", ticks, channel_on); end
    endtask

    task automatic test_reset_mid;
        int gap; bit ok; int nt;
        nr30 = 8'h80; nr33 = 8'hFF;
        write_nr34(8'h87);
        for (int i = 0; i < 40; i++) begin
            if (sample_index == 6'd17) break;
            wait_tick(20, gap, ok);
            if (!ok) break;
        end
        checks++; if (sample_index !== 6'd17) begin errors++; $display("FAIL rst_mid_reach: got %0d want 17", sample_index); end
        reset = 1'b1;
        @(negedge system_clock);
        checks++; if (channel_on !== 1'b0) begin errors++; $display("FAIL rst_mid_on: got %b want 0", channel_on); end
        checks++; if (sample_index !== 6'd0) begin errors++; $display("FAIL rst_mid_index: got %0d want 0", sample_index); end
        checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL rst_mid_tick: got %b want 0", sample_tick); end
        checks++; if (cpu_bank !== 1'b1) begin errors++; $display("FAIL rst_mid_cpu_bank: got %b want 1", cpu_bank); end
`ifdef WAVE_CTRL_LEN_READBACK_EN
        checks++; if (len_remaining !== 9'd0) begin errors++; $display("FAIL rst_mid_len: got %0d want 0", len_remaining); end
`endif
        nt = 0;
        repeat (6) begin @(negedge system_clock); if (sample_tick) nt++; end
        checks++; if (nt !== 0) begin errors++; $display("FAIL rst_mid_no_tick: got %0d want 0", nt); end
        reset = 1'b0;
        repeat (2) @(negedge system_clock);
        checks++; if (channel_on !== 1'b0 || sample_index !== 6'd0) begin errors++; $display("FAIL rst_mid_release: on=%b idx=%0d want 0 0", channel_on, sample_index); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freq();
        test_dimension();
        test_back_to_back();
        test_dac_off();
        test_length();
        test_length_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_channel_ctrl.md
Name: wave_channel_ctrl

Overview:
Sequencer for sound channel 3 (wave channel). It decodes NR30/NR31/NR33/NR34 writes and handles trigger, length-counter expiry and the DAC-off condition. It runs the frequency timer as a clock enable rather than a derived clock, and it produces the wave-RAM nibble index and bank select that the wave datapath uses to pick a sample. It sits between the sound register file and the wave sample datapath/mixer.

Parameters:
LEN_TICK_DIV, 65536, system_clock cycles per 256 Hz length tick; the minimum legal value is 2.
TIMER_MULT, 4, system_clock cycles per frequency-timer unit, so period = (2048 - f) * TIMER_MULT.

Ports:
system_clock  input  1  system clock
reset  input  1  synchronous, active-high
nr30  input  8  bit7 DAC enable, bit6 bank select, bit5 dimension (0 = 32 nibbles, 1 = 64 nibbles)
nr31  input  8  length load value
nr31_wr  input  1  one-cycle write strobe for NR31
nr33  input  8  frequency low byte
nr34  input  8  bit7 trigger, bit6 length enable, bits2:0 frequency high
nr34_wr  input  1  one-cycle write strobe for NR34
channel_on  output  1  channel is playing; mirrors the NR52 bit 2 status
sample_index  output  6  nibble index into the 64-nibble wave RAM; bit5 is the bank
sample_tick  output  1  one-cycle pulse when sample_index advances
cpu_bank  output  1  bank open to CPU access, which is the inverse of the playing bank

Behaviour:
- Reset values:
  - channel_on = 0, sample_tick = 0, sample_index = 0, cpu_bank = 1.
  - Frequency timer = 0, length counter = 0, length prescaler = 0.
  - State = OFF.
- States: OFF and PLAY.
  - OFF -> PLAY on a trigger (nr34_wr with nr34[7] = 1) while nr30[7] = 1.
  - PLAY -> OFF when nr30[7] = 0 (same cycle), or when the length counter reaches 0 with length enable set.
  - A trigger while nr30[7] = 0 leaves the state OFF.
- Frequency: f = {nr34[2:0], nr33}, 11 bits. Reload = (2048 - f) * TIMER_MULT, 13 bits; the range is 4..8192, and 8192 is stored as 0 and treated as 8192.
- Timer, in PLAY only:
  - The down-counter decrements each cycle.
  - At count 1 it reloads, and the next cycle asserts sample_tick for exactly one cycle and advances sample_index.
  - With f = 2047, sample_tick fires every 4 cycles.
- Index advance:
  - dimension = 0: bits4:0 increment and wrap 31 -> 0; bit5 is held at nr30[6].
  - dimension = 1: all 6 bits increment and wrap 63 -> 0.
- Trigger, when accepted:
  - Timer is reloaded and prescaler phase is untouched.
  - sample_index = {nr30[6], 5'd0}.
  - If the length counter is 0, it is set to 256.
  - No sample_tick in the trigger cycle.
  - A trigger in PLAY restarts identically.
- Length counter (9 bits):
  - nr31_wr loads 256 - nr31.
  - The prescaler produces a tick every LEN_TICK_DIV cycles, free-running in both states.
  - On a tick, with nr34[6] set at the last NR34 write and the counter nonzero, the counter decrements; a transition to 0 forces OFF in the same cycle.
- Simultaneous events:
  - Trigger and timer expiry in the same cycle: trigger wins, no tick.
  - Trigger and length tick: trigger load, then no decrement this cycle.
  - nr31_wr and length tick: the load wins.
  - DAC off and trigger: stays OFF.
- cpu_bank = ~sample_index[5] in PLAY and ~nr30[6] in OFF. With dimension = 1 in PLAY, cpu_bank still tracks the playing bank.
- OFF holds sample_index and timer frozen; sample_tick = 0.
- A reset asserted mid-play returns every register to its reset value on the next edge.

Optional Feature:
WAVE_CTRL_LEN_READBACK_EN.
- Defined: adds output len_remaining[8:0], the live length counter, plus output len_expired, a one-cycle pulse when length forces OFF.
- Undefined: neither port exists, and the remaining behaviour is identical.

Decomposition:
- Package snd_pkg holds:
  - The NR30/NR34 bit-position constants (DAC_EN_BIT = 7, BANK_BIT = 6, DIM_BIT = 5, TRIG_BIT = 7, LEN_EN_BIT = 6).
  - typedef enum logic {WC_OFF, WC_PLAY} wave_state_t.
  - WAVE_NIBBLES = 64.
- One sub-module, sound_length_counter (prescaler + 9-bit counter + expiry), reusable by channels 1, 2 and 4 with a MAX_LEN parameter.

Test Plan:
- Reset release, then nr30 = 0x80 and an NR34 write of 0x87 with nr33 = 0xFF -> channel_on = 1, sample_index = 0, sample_tick every 4 cycles, index 0,1,..,31,0.
- Dimension test: nr30 = 0xE0, trigger, f = 2047 -> index starts at 32, runs 32..63,0..31, wraps, and cpu_bank follows ~index[5].
- Length test: LEN_TICK_DIV = 16, nr31 = 0xFE, NR34 = 0xC7 -> channel_on drops exactly 2 length ticks after the trigger, and len_expired pulses once when enabled.
- DAC off: nr30 cleared mid-play -> channel_on = 0 the same cycle, no further sample_tick; retrigger with DAC off -> stays OFF.
- Collision: trigger on the exact timer-expiry cycle -> no sample_tick, index = bank start; nr31_wr coincident with a length tick -> counter = 256 - nr31.
- Synchronous reset asserted mid-play at index 17 -> all outputs at reset values after one edge, and no tick during reset.
